systolic_feeder: RTL and testbench
==================================

# systolic_feeder

Input-skew and sequencing stage for the N×N output-stationary systolic MAC array. It accepts one N-wide row-slice of A and one N-wide column-slice of B per beat. Each lane is delayed by its index so that operands meet diagonally in the processing elements. The block also generates the array-wide accumulator-clear pulse and the drain strobe. It sits directly upstream of the array: A lanes drive the west edge, B lanes drive the north edge, and both control strobes are broadcast to every PE.

## Interface
- N, 4: array dimension; number of A lanes and of B lanes
- W, 8: operand width
- KMAX, 256: maximum reduction depth K per block
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a block; sampled only in IDLE
- k_len  in  $clog2(KMAX+1)  beats in the block; sampled with start
- in_valid  in  1  a_vec/b_vec beat valid
- in_ready  out  1  beat accepted when in_valid & in_ready
- a_vec  in  N*W  lane i = A[i][k], bits [i*W +: W]
- b_vec  in  N*W  lane j = B[k][j]
- a_lane  out  N*W  skewed A operands to row i of the array
- a_lane_valid  out  N  per-lane valid
- b_lane  out  N*W  skewed B operands to column j
- b_lane_valid  out  N  per-lane valid
- acc_clear_block  out  1  one-cycle clear to all PEs
- drain_en  out  1  one-cycle result-valid strobe to all PEs
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, LOAD, FLUSH, DRAIN.
- IDLE → LOAD on start with 1 ≤ k_len ≤ KMAX. The block latches k_len and zeroes the beat counter.
  - start with k_len = 0 or k_len > KMAX is ignored: no state change, no clear.
  - start outside IDLE is ignored.
- LOAD:
  - in_ready = 1.
  - Each accepted beat increments the beat counter.
  - A cycle with in_valid = 0 injects a bubble (valid 0) into every lane. Bubbles do not disturb alignment because all lanes delay uniformly.
  - On acceptance of beat k_len, the block goes to FLUSH and loads the flush counter with 2N−1.
- FLUSH: in_ready = 0. The flush counter decrements each cycle; at 1 the block goes to DRAIN.
- DRAIN: lasts one cycle, then goes to IDLE.
- Skew: lane i (A and B alike) is a (1+i)-stage register line carrying {valid, data}. The stage is (valid & accepted) or a bubble. Bubble data is held at 0.
- Reset (including mid-block):
  - State returns to IDLE and counters clear.
  - All skew-line stages clear to {0, 0}, so in-flight beats are discarded.

## Timing
- Reset values: in_ready 0, busy 0, acc_clear_block 0, drain_en 0, all lane valids 0, all lane data 0.
- start accepted in cycle s → acc_clear_block = 1 and in_ready = 1 in cycle s+1 (first LOAD cycle).
- The earliest beat is accepted in cycle s+1 and reaches PE(0,0) in cycle s+2. The clear therefore always precedes the first MAC of the block.
- A beat accepted in cycle t appears on a_lane[i]/b_lane[i] in cycle t+1+i. After PE forwarding, its A and B elements coincide at PE(r,c) in cycle t+1+r+c.
- Last beat accepted in cycle T:
  - FLUSH covers cycles T+1 … T+2N−1.
  - drain_en = 1 in cycle T+2N only. This is the first cycle in which PE(N−1,N−1)'s accumulator includes beat k_len.
  - busy falls in cycle T+2N+1.
- start may be asserted in cycle T+2N+1 (IDLE). The resulting clear in T+2N+2 does not overlap drain_en.
- acc_clear_block, drain_en, in_ready and busy are Moore outputs, decoded from registered state.

## Structure
- Package systolic_pkg holds:
  - typedef feeder_state_t (IDLE, LOAD, FLUSH, DRAIN)
  - default N, W, KMAX constants, shared with the array top
  - localparam FLUSH_CYCLES = 2*N−1
- Sub-module skew_line (params DEPTH, W): a {valid, data} shift register with synchronous active-high reset. It is instantiated 2N times with DEPTH = 1+i.

## Test plan
- N=4, k_len=3, continuous in_valid from s+1:
  - clear in s+1 only
  - lane i valid in cycles s+2+i … s+4+i
  - drain_en in s+11 only
  - busy low in s+12
- Bubbles: in_valid pattern 1,0,1,1 with k_len=3:
  - every lane shows valid 1,0,1,1 shifted by i
  - bubble data is 0
  - drain_en at last-accept+8
- Ignored starts:
  - k_len=0 → no clear, busy stays 0
  - start pulsed during LOAD and FLUSH → no effect on counters or drain timing
- Reset asserted mid-LOAD after 2 beats → next cycle all valids 0, in_ready 0, busy 0. A fresh start behaves as in the first scenario.
- Back-to-back blocks: second start in the first IDLE cycle after DRAIN → clear exactly 2 cycles after drain_en, never coincident with it.
- Golden check with the array: 4×4 A, B with signed values −128…127, K=KMAX:
  - acc_out captured at drain_en matches the reference matrix product
  - no overflow of the 32-bit accumulator

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and defaults for the systolic MAC array and its feeder.
// Holds the feeder FSM state type, array defaults and flush depth.
package systolic_pkg;

  localparam int DEF_N    = 4;
  localparam int DEF_W    = 8;
  localparam int DEF_KMAX = 256;

  localparam int FLUSH_CYCLES = 2 * DEF_N - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DRAIN = 2'd3
  } feeder_state_t;

  // Cycles from the last beat until the far corner PE has it.
  function automatic int flush_len(input int n);
    return 2 * n - 1;
  endfunction

endpackage

// File: rtl/systolic_feeder_skew_line.sv
// skew_line: DEPTH-stage {valid, data} delay line, sync active-high rst.
// Ports: clk, rst, beat_valid/beat_data in, lane_valid/lane_data out.
module skew_line #(
  parameter int DEPTH = 1,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         beat_valid,
  input  logic [W-1:0] beat_data,
  output logic         lane_valid,
  output logic [W-1:0] lane_data
);

  logic [DEPTH-1:0] v;
  logic [W-1:0]     d [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      v <= '0;
      for (int i = 0; i < DEPTH; i++) d[i] <= '0;
    end else begin
      v[0] <= beat_valid;
      // bubbles carry zero data
      d[0] <= beat_valid ? beat_data : '0;
      for (int i = 1; i < DEPTH; i++) begin
        v[i] <= v[i-1];
        d[i] <= d[i-1];
      end
    end
  end

  assign lane_valid = v[DEPTH-1];
  assign lane_data  = d[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// Input skew and sequencing for the NxN output-stationary MAC array.
// Ports: start/k_len, in_valid/in_ready, a_vec/b_vec in; skewed lanes,
// acc_clear_block, drain_en, busy out.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int N    = DEF_N,
  parameter int W    = DEF_W,
  parameter int KMAX = DEF_KMAX,
  parameter int KW   = $clog2(KMAX + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [KW-1:0]  k_len,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] a_vec,
  input  logic [N*W-1:0] b_vec,
  output logic [N*W-1:0] a_lane,
  output logic [N-1:0]   a_lane_valid,
  output logic [N*W-1:0] b_lane,
  output logic [N-1:0]   b_lane_valid,
  output logic           acc_clear_block,
  output logic           drain_en,
  output logic           busy
);

  localparam int FL = flush_len(N);
  localparam int FW = $clog2(FL + 1);

  feeder_state_t state;
  logic [KW-1:0] k_q;
  logic [KW-1:0] beat_q;
  logic [FW-1:0] fcnt;
  logic          first_q;
  logic          take;
  logic          start_ok;

  assign take     = in_valid & in_ready;
  assign start_ok = start && (k_len != '0)
                    && (int'(k_len) <= KMAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      k_q     <= '0;
      beat_q  <= '0;
      fcnt    <= '0;
      first_q <= 1'b0;
    end else begin
      first_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ok) begin
            state   <= LOAD;
            k_q     <= k_len;
            beat_q  <= '0;
            first_q <= 1'b1;
          end
        end
        LOAD: begin
          if (take) begin
            beat_q <= beat_q + KW'(1);
            if (beat_q + KW'(1) == k_q) begin
              state <= FLUSH;
              fcnt  <= FW'(FL);
            end
          end
        end
        FLUSH: begin
          fcnt <= fcnt - FW'(1);
          if (fcnt == FW'(1)) state <= DRAIN;
        end
        DRAIN:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // first_q marks the first LOAD cycle only
  assign acc_clear_block = first_q;
  assign in_ready        = (state == LOAD);
  assign drain_en        = (state == DRAIN);
  assign busy            = (state != IDLE);

  for (genvar i = 0; i < N; i++) begin : g_lane
    skew_line #(.DEPTH(1 + i), .W(W)) u_a (
      .clk        (clk),
      .rst        (rst),
      .beat_valid (take),
      .beat_data  (a_vec[i*W +: W]),
      .lane_valid (a_lane_valid[i]),
      .lane_data  (a_lane[i*W +: W])
    );
    skew_line #(.DEPTH(1 + i), .W(W)) u_b (
      .clk        (clk),
      .rst        (rst),
      .beat_valid (take),
      .beat_data  (b_vec[i*W +: W]),
      .lane_valid (b_lane_valid[i]),
      .lane_data  (b_lane[i*W +: W])
    );
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder with a behavioural 4x4 PE array.
// Checks skew, bubbles, control strobes, reset and a golden product.
module tb_systolic_feeder;

  localparam int N    = 4;
  localparam int W    = 8;
  localparam int KMAX = 256;
  localparam int KW   = $clog2(KMAX + 1);
  localparam int LOGN = 2048;

  logic           clk;
  logic           rst;
  logic           start;
  logic [KW-1:0]  k_len;
  logic           in_valid;
  logic           in_ready;
  logic [N*W-1:0] a_vec;
  logic [N*W-1:0] b_vec;
  logic [N*W-1:0] a_lane;
  logic [N-1:0]   a_lane_valid;
  logic [N*W-1:0] b_lane;
  logic [N-1:0]   b_lane_valid;
  logic           acc_clear_block;
  logic           drain_en;
  logic           busy;

  systolic_feeder #(.N(N), .W(W), .KMAX(KMAX)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .k_len           (k_len),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .a_vec           (a_vec),
    .b_vec           (b_vec),
    .a_lane          (a_lane),
    .a_lane_valid    (a_lane_valid),
    .b_lane          (b_lane),
    .b_lane_valid    (b_lane_valid),
    .acc_clear_block (acc_clear_block),
    .drain_en        (drain_en),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic           clr_l [LOGN];
  logic           drn_l [LOGN];
  logic           bsy_l [LOGN];
  logic           rdy_l [LOGN];
  logic [N-1:0]   av_l  [LOGN];
  logic [N-1:0]   bv_l  [LOGN];
  logic [N*W-1:0] ad_l  [LOGN];
  logic [N*W-1:0] bd_l  [LOGN];

  always @(negedge clk) begin
    if (cyc < LOGN) begin
      clr_l[cyc] = acc_clear_block;
      drn_l[cyc] = drain_en;
      bsy_l[cyc] = busy;
      rdy_l[cyc] = in_ready;
      av_l[cyc]  = a_lane_valid;
      bv_l[cyc]  = b_lane_valid;
      ad_l[cyc]  = a_lane;
      bd_l[cyc]  = b_lane;
    end
  end

  // behavioural output-stationary array fed by the lanes
  logic signed [W-1:0] pa  [N][N];
  logic signed [W-1:0] pb  [N][N];
  logic                pav [N][N];
  logic                pbv [N][N];
  logic signed [31:0]  acc [N][N];

  always @(posedge clk) begin
    logic signed [W-1:0] wa, wb;
    logic wav, wbv;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        if (c == 0) begin
          wa  = a_lane[r*W +: W];
          wav = a_lane_valid[r];
        end else begin
          wa  = pa[r][c-1];
          wav = pav[r][c-1];
        end
        if (r == 0) begin
          wb  = b_lane[c*W +: W];
          wbv = b_lane_valid[c];
        end else begin
          wb  = pb[r-1][c];
          wbv = pbv[r-1][c];
        end
        pa[r][c]  <= wa;
        pav[r][c] <= wav;
        pb[r][c]  <= wb;
        pbv[r][c] <= wbv;
        if (acc_clear_block) acc[r][c] <= '0;
        else if (wav === 1'b1 && wbv === 1'b1)
          acc[r][c] <= acc[r][c] + 32'(wa * wb);
      end
    end
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [N*W-1:0] beat_a(input int k);
    logic [N*W-1:0] v;
    for (int i = 0; i < N; i++) v[i*W +: W] = W'(16 * (k + 1) + i);
    return v;
  endfunction

  function automatic logic [N*W-1:0] beat_b(input int k);
    logic [N*W-1:0] v;
    for (int i = 0; i < N; i++) v[i*W +: W] = W'(128 + 16 * k + i);
    return v;
  endfunction

  task automatic run_basic(input string nm);
    int s;
    logic [N*W-1:0] ta, tb;
    s = cyc;
    start = 1'b1;
    k_len = KW'(3);
    step();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      a_vec = beat_a(k);
      b_vec = beat_b(k);
      step();
    end
    in_valid = 1'b0;
    a_vec = '0;
    b_vec = '0;
    step(12);
    check({nm, "_clr_s"}, clr_l[s], 0);
    check({nm, "_clr_s1"}, clr_l[s+1], 1);
    check({nm, "_clr_s2"}, clr_l[s+2], 0);
    check({nm, "_rdy_s1"}, rdy_l[s+1], 1);
    for (int i = 0; i < N; i++) begin
      for (int c = s + 1; c <= s + 6 + i; c++) begin
        check($sformatf("%s_av%0d_c%0d", nm, i, c - s), av_l[c][i],
              (c >= s + 2 + i && c <= s + 4 + i) ? 1 : 0);
        check($sformatf("%s_bv%0d_c%0d", nm, i, c - s), bv_l[c][i],
              (c >= s + 2 + i && c <= s + 4 + i) ? 1 : 0);
      end
      for (int k = 0; k < 3; k++) begin
        ta = beat_a(k);
        tb = beat_b(k);
        check($sformatf("%s_ad%0d_k%0d", nm, i, k),
              ad_l[s+2+i+k][i*W +: W], ta[i*W +: W]);
        check($sformatf("%s_bd%0d_k%0d", nm, i, k),
              bd_l[s+2+i+k][i*W +: W], tb[i*W +: W]);
      end
    end
    check({nm, "_drn_s10"}, drn_l[s+10], 0);
    check({nm, "_drn_s11"}, drn_l[s+11], 1);
    check({nm, "_drn_s12"}, drn_l[s+12], 0);
    check({nm, "_bsy_s11"}, bsy_l[s+11], 1);
    check({nm, "_bsy_s12"}, bsy_l[s+12], 0);
  endtask

  task automatic run_bubble();
    int s;
    logic pat [4];
    logic [N*W-1:0] ta, tb;
    pat = '{1'b1, 1'b0, 1'b1, 1'b1};
    s = cyc;
    start = 1'b1;
    k_len = KW'(3);
    step();
    start = 1'b0;
    for (int m = 0; m < 4; m++) begin
      in_valid = pat[m];
      a_vec = pat[m] ? beat_a(m) : '1;
      b_vec = pat[m] ? beat_b(m) : '1;
      step();
    end
    in_valid = 1'b0;
    a_vec = '0;
    b_vec = '0;
    step(12);
    for (int i = 0; i < N; i++) begin
      for (int m = 0; m < 4; m++) begin
        ta = pat[m] ? beat_a(m) : '0;
        tb = pat[m] ? beat_b(m) : '0;
        check($sformatf("bub_av%0d_m%0d", i, m), av_l[s+2+i+m][i], pat[m]);
        check($sformatf("bub_bv%0d_m%0d", i, m), bv_l[s+2+i+m][i], pat[m]);
        check($sformatf("bub_ad%0d_m%0d", i, m),
              ad_l[s+2+i+m][i*W +: W], ta[i*W +: W]);
        check($sformatf("bub_bd%0d_m%0d", i, m),
              bd_l[s+2+i+m][i*W +: W], tb[i*W +: W]);
      end
    end
    check("bub_drn_s11", drn_l[s+11], 0);
    check("bub_drn_s12", drn_l[s+12], 1);
    check("bub_drn_s13", drn_l[s+13], 0);
  endtask

  task automatic run_ignored();
    int s;
    s = cyc;
    start = 1'b1;
    k_len = KW'(0);
    step();
    start = 1'b0;
    step(2);
    check("ign_k0_clr", clr_l[s+1], 0);
    check("ign_k0_bsy1", bsy_l[s+1], 0);
    check("ign_k0_bsy2", bsy_l[s+2], 0);
    check("ign_k0_rdy", rdy_l[s+1], 0);
    s = cyc;
    start = 1'b1;
    k_len = KW'(300);
    step();
    start = 1'b0;
    step(2);
    check("ign_kbig_clr", clr_l[s+1], 0);
    check("ign_kbig_bsy", bsy_l[s+1], 0);
    s = cyc;
    start = 1'b1;
    k_len = KW'(2);
    step();
    k_len = KW'(1);
    in_valid = 1'b1;
    a_vec = beat_a(0);
    b_vec = beat_b(0);
    step();
    start = 1'b0;
    a_vec = beat_a(1);
    b_vec = beat_b(1);
    step();
    in_valid = 1'b0;
    step();
    start = 1'b1;
    k_len = KW'(5);
    step();
    start = 1'b0;
    step(10);
    check("ign_run_clr1", clr_l[s+1], 1);
    check("ign_run_clr2", clr_l[s+2], 0);
    check("ign_run_clr5", clr_l[s+5], 0);
    check("ign_run_rdy3", rdy_l[s+3], 0);
    check("ign_run_drn9", drn_l[s+9], 0);
    check("ign_run_drn10", drn_l[s+10], 1);
    check("ign_run_bsy11", bsy_l[s+11], 0);
  endtask

  task automatic run_reset();
    int s;
    s = cyc;
    start = 1'b1;
    k_len = KW'(4);
    step();
    start = 1'b0;
    in_valid = 1'b1;
    a_vec = beat_a(0);
    b_vec = beat_b(0);
    step();
    a_vec = beat_a(1);
    b_vec = beat_b(1);
    step();
    in_valid = 1'b0;
    a_vec = '0;
    b_vec = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step(2);
    check("rst_pre_av0", av_l[s+3][0], 1);
    check("rst_av", av_l[s+4], 0);
    check("rst_bv", bv_l[s+4], 0);
    check("rst_ad", ad_l[s+4], 0);
    check("rst_bd", bd_l[s+4], 0);
    check("rst_rdy", rdy_l[s+4], 0);
    check("rst_bsy", bsy_l[s+4], 0);
    check("rst_bsy5", bsy_l[s+5], 0);
  endtask

  task automatic run_b2b();
    int s;
    s = cyc;
    start = 1'b1;
    k_len = KW'(1);
    step();
    start = 1'b0;
    in_valid = 1'b1;
    a_vec = beat_a(0);
    b_vec = beat_b(0);
    step();
    in_valid = 1'b0;
    step(8);
    start = 1'b1;
    k_len = KW'(1);
    step();
    start = 1'b0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(12);
    check("b2b_drn9", drn_l[s+9], 1);
    check("b2b_clr9", clr_l[s+9], 0);
    check("b2b_drn10", drn_l[s+10], 0);
    check("b2b_bsy10", bsy_l[s+10], 0);
    check("b2b_clr11", clr_l[s+11], 1);
    check("b2b_drn11", drn_l[s+11], 0);
    check("b2b_drn19", drn_l[s+19], 1);
  endtask

  logic signed [W-1:0] ga [N][KMAX];
  logic signed [W-1:0] gb [KMAX][N];

  task automatic run_golden();
    int s;
    int dc;
    bit got;
    longint rf;
    logic signed [31:0] snap [N][N];
    for (int k = 0; k < KMAX; k++) begin
      for (int i = 0; i < N; i++) begin
        if (k < 2) begin
          ga[i][k] = (k == 0) ? -8'sd128 : 8'sd127;
          gb[k][i] = (k == 0) ? -8'sd128 : 8'sd127;
        end else begin
          ga[i][k] = W'($urandom_range(0, 255));
          gb[k][i] = W'($urandom_range(0, 255));
        end
      end
    end
    s = cyc;
    start = 1'b1;
    k_len = KW'(KMAX);
    step();
    start = 1'b0;
    for (int k = 0; k < KMAX; k++) begin
      in_valid = 1'b1;
      for (int i = 0; i < N; i++) begin
        a_vec[i*W +: W] = ga[i][k];
        b_vec[i*W +: W] = gb[k][i];
      end
      step();
    end
    in_valid = 1'b0;
    got = 1'b0;
    dc = 0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (drain_en) begin
        got = 1'b1;
        dc = cyc;
        for (int r = 0; r < N; r++)
          for (int c = 0; c < N; c++) snap[r][c] = acc[r][c];
      end
    end
    check("gold_drain_seen", got, 1);
    check("gold_drain_cyc", dc, s + KMAX + 8);
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        rf = 0;
        for (int k = 0; k < KMAX; k++)
          rf += longint'(ga[r][k]) * longint'(gb[k][c]);
        check($sformatf("gold_acc_%0d_%0d", r, c),
              64'(longint'(snap[r][c])), 64'(rf));
      end
    end
    step(3);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    k_len = '0;
    in_valid = 1'b0;
    a_vec = '0;
    b_vec = '0;
    step(3);
    check("rst0_rdy", rdy_l[2], 0);
    check("rst0_bsy", bsy_l[2], 0);
    check("rst0_clr", clr_l[2], 0);
    check("rst0_drn", drn_l[2], 0);
    check("rst0_av", av_l[2], 0);
    check("rst0_bv", bv_l[2], 0);
    check("rst0_ad", ad_l[2], 0);
    check("rst0_bd", bd_l[2], 0);
    rst = 1'b0;
    step(2);
    run_basic("basic");
    run_bubble();
    run_ignored();
    run_reset();
    run_basic("again");
    run_b2b();
    run_golden();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
